// File: rtl/sram_rd_responder_if.sv
// sram_rd_responder_if: read-address / read-data handshake bundle
//   master: initiator side (drives arvalid, araddr, rready)
//   slave:  responder side (drives arready, rvalid, rresp, rdata)
interface sram_rd_responder_if #(parameter int DATA_LEN = 32);
  logic                arvalid;
  logic                arready;
  logic [DATA_LEN-1:0] araddr;
  logic                rvalid;
  logic                rready;
  logic [2:0]          rresp;
  logic [DATA_LEN-1:0] rdata;
  modport master (output arvalid, araddr, rready, input arready, rvalid, rresp, rdata);
  modport slave (input arvalid, araddr, rready, output arready, rvalid, rresp, rdata);
endinterface

// File: rtl/sram_rd_responder.sv
// sram_rd_responder: single-outstanding SRAM read responder with programmable latency
//   clk, rst      : clock, synchronous active-high reset
//   bus           : AR/R handshake (slave modport)
//   delay_cfg     : extra wait cycles, captured at the AR handshake
//   mem_wen/waddr/wdata : backdoor word write port, active in every state and during reset
module sram_rd_responder #(
  parameter int                  DATA_LEN   = 32,
  parameter logic [DATA_LEN-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int                  DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_rd_responder_if.slave    bus,
  input  logic [3:0]            delay_cfg,
  input  logic                  mem_wen,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [DATA_LEN-1:0]   mem_wdata
);
  localparam int OFS = $clog2(DATA_LEN / 8);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_LEN-1:0] addr_q, off, rdata_q;
  logic [3:0]          cnt_q;
  logic [2:0]          rresp_q;
  logic                dec_err, mis;
  // offset wraps modulo 2^DATA_LEN; any bit above the word-index field is out of range
  assign off     = addr_q - BASE_ADDR;
  assign dec_err = (addr_q < BASE_ADDR) || |(off >> (OFS + DEPTH_LOG2));
  assign mis     = |addr_q[OFS-1:0];
  assign bus.arready = state_q == IDLE;
  assign bus.rvalid  = state_q == RESP;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.arvalid ? WAIT : IDLE;
      WAIT:    state_d = cnt_q == 4'd0 ? RESP : WAIT;
      RESP:    state_d = bus.rready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rresp_q <= 3'b000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.arvalid) begin
        addr_q <= bus.araddr;
        cnt_q  <= delay_cfg;
      end
      if (state_q == WAIT) begin
        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          rresp_q <= dec_err ? 3'b011 : mis ? 3'b010 : 3'b000;
          rdata_q <= (dec_err || mis) ? '0 : mem[off[OFS +: DEPTH_LOG2]];
        end
      end
    end
  // no reset on the array; the nonblocking write gives read-before-write against rdata_q
  always_ff @(posedge clk)
    if (mem_wen) mem[mem_waddr] <= mem_wdata;
endmodule

// File: doc/sram_rd_responder.md
SRAM_RD_RESPONDER -- requirements
Module: sram_rd_responder

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, read data width in bits (32 or 64).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12, log2 of the number of DATA_LEN-bit words.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port arvalid, input, 1, read request valid.
REQ-007 SHALL have port arready, output, 1, responder can accept a request.
REQ-008 SHALL have port araddr, input, DATA_LEN, byte read address.
REQ-009 SHALL have port rvalid, output, 1, read response valid.
REQ-010 SHALL have port rready, input, 1, initiator accepts the response.
REQ-011 SHALL have port rresp, output, 3, response code: 3'b000 OKAY, 3'b010 misaligned, 3'b011 decode error.
REQ-012 SHALL have port rdata, output, DATA_LEN, read data.
REQ-013 SHALL have port delay_cfg, input, 4, extra response wait cycles, sampled at the AR handshake.
REQ-014 SHALL have port mem_wen, input, 1, backdoor word write enable.
REQ-015 SHALL have port mem_waddr, input, DEPTH_LOG2, backdoor word index.
REQ-016 SHALL have port mem_wdata, input, DATA_LEN, backdoor write data.

Function
REQ-017 AR handshake SHALL be arvalid&arready; R handshake SHALL be rvalid&rready.
REQ-018 The FSM SHALL have three states: IDLE (arready=1), WAIT (arready=0, rvalid=0) and RESP (arready=0, rvalid=1).
REQ-019 On an AR handshake in IDLE, the block SHALL:
- latch araddr;
- load the wait counter with delay_cfg;
- go to WAIT.
REQ-020 In WAIT with counter nonzero, the counter SHALL decrement by 1; with counter zero, the block SHALL go to RESP and register rdata/rresp on that edge.
REQ-021 Latency: handshake at edge k SHALL produce rvalid=1 from edge k+1+delay_cfg (delay_cfg=0 gives 1 cycle; delay_cfg=15 gives 16 cycles).
REQ-022 In RESP, rvalid, rdata and rresp SHALL hold stable until the R handshake.
REQ-023 On the R handshake, the block SHALL go to IDLE with rvalid=0 and arready=1 on the next edge; a new request is accepted no earlier than the cycle after that.
REQ-024 Decode SHALL use offset = araddr - BASE_ADDR (modulo 2^DATA_LEN) and word index = offset >> log2(DATA_LEN/8).
REQ-025 Response selection SHALL be:
- araddr < BASE_ADDR or word index >= 2^DEPTH_LOG2: rresp 3'b011, rdata 0 (decode error takes precedence);
- otherwise, low log2(DATA_LEN/8) address bits nonzero: rresp 3'b010, rdata 0;
- otherwise: rresp 3'b000, rdata = mem[word index].
REQ-026 Backdoor writes SHALL take effect on the edge where mem_wen=1, in any state, and SHALL NOT alter arready, rvalid or the FSM.
REQ-027 A backdoor write to the word being read on the WAIT->RESP edge SHALL NOT be visible in that response (read-before-write); writes before that edge SHALL be visible.
REQ-028 arvalid SHALL be ignored outside IDLE; rready SHALL be ignored outside RESP.
REQ-029 delay_cfg changes after the AR handshake SHALL NOT affect the pending request.
REQ-030 One request at most SHALL be outstanding; there is no queueing.

Reset
REQ-031 While rst=1 at an edge:
- state SHALL become IDLE;
- arready=1, rvalid=0, rresp=3'b000, rdata=0;
- wait counter=0.
REQ-032 Reset during WAIT or RESP SHALL drop the pending response with no rvalid pulse afterward.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 mem_wen SHALL still write while rst=1.

Verification
REQ-035 Preload mem[0]=32'h1234_5678; read araddr=32'h8000_0000, delay_cfg=0, rready=1 -> rvalid one cycle after handshake, rdata=32'h1234_5678, rresp=000, arready=1 two cycles after handshake.
REQ-036 delay_cfg=5, read 32'h8000_0004 (mem[1]=32'hDEAD_BEEF), rready held low 3 cycles after rvalid -> rvalid at handshake+6, data/resp stable for 4 cycles, single R handshake.
REQ-037 Read 32'h8000_0002 -> rresp=010, rdata=0; read 32'h7FFF_FFFC -> rresp=011; read 32'h8000_4000 (DEPTH_LOG2=12) -> rresp=011.
REQ-038 Read mem[3] with delay_cfg=2 and backdoor write mem[3]=32'hAAAA_AAAA on the WAIT->RESP edge -> old value returned; next read of mem[3] returns 32'hAAAA_AAAA.
REQ-039 Assert rst during WAIT -> next cycle arready=1, rvalid=0, no response ever issued; next request completes normally.
REQ-040 Back-to-back 16-word burst of sequential reads (4 per line, as a cache refill) with rready=1 and random delay_cfg -> all data match preload, no dropped or duplicated responses.
